// File: rtl/ldst_imem_pkg.sv
// Shared constants, state encoding and address helper for the instruction memory.
package ldst_imem_pkg;

    localparam int                    DATA_WIDTH   = 13;
    localparam logic [15:0]           HALT_ADDRESS = 16'hFFFF;
    localparam logic [DATA_WIDTH-1:0] ERROR_WORD   = 13'h1FFF;

    typedef enum logic [2:0] {
        ST_LOAD    = 3'd0,
        ST_IDLE    = 3'd1,
        ST_WAIT    = 3'd2,
        ST_RESPOND = 3'd3,
        ST_HALT    = 3'd4
    } imem_state_e;

    // True when the word address falls inside the 2**depth_log2 stored words.
    function automatic logic addr_in_range(input logic [15:0] addr, input int unsigned depth_log2);
        return (({16'h0000, addr} >> depth_log2) == 32'd0);
    endfunction

endpackage

// File: rtl/ldst_imem_if.sv
// Loader and sequencer bus bundle for ldst_instruction_memory.
interface ldst_imem_if;
    import ldst_imem_pkg::*;

    // Loader: a word transfers on a rising clock edge where load_valid and load_ready
    // are both high. Sequencer: a request is taken only when the memory is idle; it
    // must then hold off until instruction_bus_valid pulses for one cycle.
    logic                  load_valid;
    logic [15:0]           load_address;
    logic [DATA_WIDTH-1:0] load_data;
    logic                  load_ready;
    logic                  load_done;
    logic                  instruction_bus_request;
    logic [15:0]           instruction_bus_address;
    logic [DATA_WIDTH-1:0] instruction_bus_data;
    logic                  instruction_bus_valid;
    logic                  address_error;
    logic                  halted;
    logic [2:0]            debug_state;

    modport master (
        output load_valid, load_address, load_data, load_done,
        output instruction_bus_request, instruction_bus_address,
        input  load_ready, instruction_bus_data, instruction_bus_valid,
        input  address_error, halted, debug_state
    );

    modport slave (
        input  load_valid, load_address, load_data, load_done,
        input  instruction_bus_request, instruction_bus_address,
        output load_ready, instruction_bus_data, instruction_bus_valid,
        output address_error, halted, debug_state
    );

endinterface

// File: rtl/ldst_imem_array.sv
// Program storage: one write port, one registered read port, contents never reset.
module ldst_imem_array
    import ldst_imem_pkg::*;
#(
    parameter int DEPTH_LOG2 = 8
) (
    input  logic                  clock,
    input  logic                  wr_en,
    input  logic [DEPTH_LOG2-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [DEPTH_LOG2-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem_q [2**DEPTH_LOG2];
    logic [DATA_WIDTH-1:0] rd_data_q;

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data_q <= mem_q[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/ldst_instruction_memory.sv
// Instruction memory: loaded once by the loader, then serves sequencer fetches.
// Define LDST_IMEM_WAIT_EN to add WAIT_CYCLES extra response latency.
module ldst_instruction_memory
    import ldst_imem_pkg::*;
#(
    parameter int DEPTH_LOG2  = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic       clock,
    input  logic       reset,
    ldst_imem_if.slave bus
);

    localparam logic [2:0] S_LOAD    = 3'(ST_LOAD);
    localparam logic [2:0] S_IDLE    = 3'(ST_IDLE);
    localparam logic [2:0] S_RESPOND = 3'(ST_RESPOND);
    localparam logic [2:0] S_HALT    = 3'(ST_HALT);
`ifdef LDST_IMEM_WAIT_EN
    localparam logic [2:0] S_WAIT    = 3'(ST_WAIT);
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);
`endif

    if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_wait_cycles_check
        $error("WAIT_CYCLES must be in 0..15");
    end

    logic [2:0]            state_q, state_d;
    logic                  err_q, err_d;
    logic                  resp_phase_q, resp_phase_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  address_error_q, address_error_d;
    logic                  halted_q, halted_d;
`ifdef LDST_IMEM_WAIT_EN
    logic [3:0]            wait_cnt_q, wait_cnt_d;
`endif

    logic                  fetch_in_range;
    logic                  load_in_range;
    logic                  mem_wr_en;
    logic                  mem_rd_en;
    logic [DATA_WIDTH-1:0] mem_rd_data;

    assign fetch_in_range = addr_in_range(bus.instruction_bus_address, DEPTH_LOG2);
    assign load_in_range  = addr_in_range(bus.load_address, DEPTH_LOG2);

    ldst_imem_array #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_array (
        .clock  (clock),
        .wr_en  (mem_wr_en),
        .wr_addr(bus.load_address[DEPTH_LOG2-1:0]),
        .wr_data(bus.load_data),
        .rd_en  (mem_rd_en),
        .rd_addr(bus.instruction_bus_address[DEPTH_LOG2-1:0]),
        .rd_data(mem_rd_data)
    );

    always_comb begin
        state_d         = state_q;
        err_d           = err_q;
        resp_phase_d    = resp_phase_q;
        data_d          = data_q;
        valid_d         = 1'b0;
        address_error_d = address_error_q;
        halted_d        = halted_q;
        mem_wr_en       = 1'b0;
        mem_rd_en       = 1'b0;
`ifdef LDST_IMEM_WAIT_EN
        wait_cnt_d      = wait_cnt_q;
`endif

        case (state_q)
            S_LOAD: begin
                if (bus.load_valid) begin
                    if (load_in_range) begin
                        mem_wr_en = 1'b1;
                    end else if (bus.load_address != HALT_ADDRESS) begin
                        address_error_d = 1'b1;
                    end
                end
                if (bus.load_done) begin
                    state_d = S_IDLE;
                end
            end

            S_IDLE: begin
                if (bus.instruction_bus_request) begin
                    if (bus.instruction_bus_address == HALT_ADDRESS) begin
                        state_d  = S_HALT;
                        halted_d = 1'b1;
                    end else begin
                        // The array's registered read port captures the fetch address here.
                        mem_rd_en    = fetch_in_range;
                        err_d        = !fetch_in_range;
                        resp_phase_d = 1'b0;
                        if (!fetch_in_range) begin
                            address_error_d = 1'b1;
                        end
`ifdef LDST_IMEM_WAIT_EN
                        if (WAIT_CYCLES > 0) begin
                            state_d    = S_WAIT;
                            wait_cnt_d = WAIT_INIT;
                        end else begin
                            state_d = S_RESPOND;
                        end
`else
                        state_d = S_RESPOND;
`endif
                    end
                end
            end

`ifdef LDST_IMEM_WAIT_EN
            S_WAIT: begin
                wait_cnt_d = wait_cnt_q - 4'd1;
                if (wait_cnt_q <= 4'd1) begin
                    state_d = S_RESPOND;
                end
            end
`endif

            // Two cycles: the first lets the read settle, the second registers the word
            // and the valid pulse together with the return to IDLE.
            S_RESPOND: begin
                if (!resp_phase_q) begin
                    resp_phase_d = 1'b1;
                end else begin
                    resp_phase_d = 1'b0;
                    valid_d      = 1'b1;
                    data_d       = err_q ? ERROR_WORD : mem_rd_data;
                    state_d      = S_IDLE;
                end
            end

            S_HALT: begin
                state_d = S_HALT;
            end

            default: begin
                state_d = S_LOAD;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q         <= S_LOAD;
            err_q           <= 1'b0;
            resp_phase_q    <= 1'b0;
            data_q          <= '0;
            valid_q         <= 1'b0;
            address_error_q <= 1'b0;
            halted_q        <= 1'b0;
`ifdef LDST_IMEM_WAIT_EN
            wait_cnt_q      <= 4'd0;
`endif
        end else begin
            state_q         <= state_d;
            err_q           <= err_d;
            resp_phase_q    <= resp_phase_d;
            data_q          <= data_d;
            valid_q         <= valid_d;
            address_error_q <= address_error_d;
            halted_q        <= halted_d;
`ifdef LDST_IMEM_WAIT_EN
            wait_cnt_q      <= wait_cnt_d;
`endif
        end
    end

    assign bus.load_ready            = (state_q == S_LOAD);
    assign bus.instruction_bus_data  = data_q;
    assign bus.instruction_bus_valid = valid_q;
    assign bus.address_error         = address_error_q;
    assign bus.halted                = halted_q;
    assign bus.debug_state           = state_q;

endmodule

// File: tb/tb_ldst_instruction_memory.sv
// Self-checking bench for ldst_instruction_memory (either LDST_IMEM_WAIT_EN build).
module tb_ldst_instruction_memory;

    localparam int DEPTH_LOG2  = 8;
    localparam int WAIT_CYCLES = 3;
`ifdef LDST_IMEM_WAIT_EN
    localparam int LAT = 2 + WAIT_CYCLES;
`else
    localparam int LAT = 2;
`endif
    localparam logic [2:0]  EXP_LOAD = 3'd0;
    localparam logic [2:0]  EXP_IDLE = 3'd1;
    localparam logic [2:0]  EXP_HALT = 3'd4;
    localparam logic [12:0] EXP_ERR  = 13'h1FFF;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad   = 0;
    logic [12:0] exp_q[$];

    ldst_imem_if bus_if ();

    ldst_instruction_memory #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .WAIT_CYCLES(WAIT_CYCLES)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus_if)
    );

    // ---------------- clock / reset ----------------
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        bus_if.load_valid              = 1'b0;
        bus_if.load_address            = 16'h0000;
        bus_if.load_data               = 13'h0000;
        bus_if.load_done               = 1'b0;
        bus_if.instruction_bus_request = 1'b0;
        bus_if.instruction_bus_address = 16'h0000;
    endtask

    // ---------------- driver tasks ----------------
    task automatic load_word(input logic [15:0] addr, input logic [12:0] data, input logic done);
        bus_if.load_valid   = 1'b1;
        bus_if.load_address = addr;
        bus_if.load_data    = data;
        bus_if.load_done    = done;
        tick();
        bus_if.load_valid   = 1'b0;
        bus_if.load_done    = 1'b0;
    endtask

    task automatic pulse_done();
        bus_if.load_done = 1'b1;
        tick();
        bus_if.load_done = 1'b0;
    endtask

    // Issues one fetch, pushes its expected word and scores the response.
    task automatic fetch(input logic [15:0] addr, input logic [12:0] exp_data,
                         input bit check_pulse, input bit hold_req);
        int n;
        logic [12:0] exp;
        exp_q.push_back(exp_data);
        bus_if.instruction_bus_request = 1'b1;
        bus_if.instruction_bus_address = addr;
        tick();
        if (!hold_req) bus_if.instruction_bus_request = 1'b0;
        n = 0;
        while (bus_if.instruction_bus_valid !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        bus_if.instruction_bus_request = 1'b0;
        exp = exp_q.pop_front();
        total++;
        if (bus_if.instruction_bus_valid !== 1'b1) begin
            bad++;
            $display("FAIL fetch_timeout addr=%h no valid after %0d cycles", addr, n);
        end else begin
            total++;
            if (n != LAT) begin
                bad++;
                $display("FAIL fetch_latency addr=%h got=%0d exp=%0d", addr, n, LAT);
            end
            total++;
            if (bus_if.instruction_bus_data !== exp) begin
                bad++;
                $display("FAIL fetch_data addr=%h got=%h exp=%h", addr, bus_if.instruction_bus_data, exp);
            end
            if (check_pulse) begin
                tick();
                total++;
                if (bus_if.instruction_bus_valid !== 1'b0) begin
                    bad++;
                    $display("FAIL valid_pulse addr=%h got=%b exp=0", addr, bus_if.instruction_bus_valid);
                end
                total++;
                if (bus_if.instruction_bus_data !== exp) begin
                    bad++;
                    $display("FAIL data_hold addr=%h got=%h exp=%h", addr, bus_if.instruction_bus_data, exp);
                end
            end
        end
    endtask

    task automatic expect_no_valid(input int cycles, input string name);
        int seen;
        seen = 0;
        repeat (cycles) begin
            tick();
            if (bus_if.instruction_bus_valid === 1'b1) seen++;
        end
        total++;
        if (seen != 0) begin
            bad++;
            $display("FAIL %s valid_pulses got=%0d exp=0", name, seen);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        repeat (2) tick();
        total++; if (bus_if.debug_state !== EXP_LOAD) begin bad++; $display("FAIL rst_state got=%h exp=%h", bus_if.debug_state, EXP_LOAD); end
        total++; if (bus_if.instruction_bus_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", bus_if.instruction_bus_valid); end
        total++; if (bus_if.instruction_bus_data !== 13'h0000) begin bad++; $display("FAIL rst_data got=%h exp=0000", bus_if.instruction_bus_data); end
        total++; if (bus_if.address_error !== 1'b0) begin bad++; $display("FAIL rst_address_error got=%b exp=0", bus_if.address_error); end
        total++; if (bus_if.halted !== 1'b0) begin bad++; $display("FAIL rst_halted got=%b exp=0", bus_if.halted); end
        reset = 1'b0;
        tick();
        total++; if (bus_if.load_ready !== 1'b1) begin bad++; $display("FAIL rst_load_ready got=%b exp=1", bus_if.load_ready); end
    endtask

    task automatic test_load_and_fetch();
        logic [12:0] w10;
        w10 = 13'($urandom_range(0, 8191));
        for (int i = 0; i < 4; i++) load_word(16'(i), 13'(i + 1), 1'b0);
        load_word(16'd10, w10, 1'b0);
        total++; if (bus_if.debug_state !== EXP_LOAD) begin bad++; $display("FAIL load_state got=%h exp=%h", bus_if.debug_state, EXP_LOAD); end
        pulse_done();
        total++; if (bus_if.debug_state !== EXP_IDLE) begin bad++; $display("FAIL done_state got=%h exp=%h", bus_if.debug_state, EXP_IDLE); end
        total++; if (bus_if.load_ready !== 1'b0) begin bad++; $display("FAIL idle_load_ready got=%b exp=0", bus_if.load_ready); end
        // A load offered outside LOAD must not overwrite word 0.
        load_word(16'd0, 13'h0555, 1'b0);
        fetch(16'd2, 13'h0003, 1'b1, 1'b0);
        fetch(16'd0, 13'h0001, 1'b1, 1'b0);
        fetch(16'd10, w10, 1'b1, 1'b0);
        fetch(16'd3, 13'h0004, 1'b1, 1'b1);
    endtask

    task automatic test_back_to_back();
        int a;
        for (int i = 0; i < 6; i++) begin
            a = $urandom_range(0, 3);
            fetch(16'(a), 13'(a + 1), 1'b0, 1'b0);
        end
        tick();
    endtask

    task automatic test_wait_states();
        fetch(16'd1, 13'h0002, 1'b1, 1'b0);
    endtask

    task automatic test_out_of_range();
        total++; if (bus_if.address_error !== 1'b0) begin bad++; $display("FAIL aerr_before got=%b exp=0", bus_if.address_error); end
        fetch(16'h0100, EXP_ERR, 1'b1, 1'b0);
        total++; if (bus_if.address_error !== 1'b1) begin bad++; $display("FAIL aerr_set got=%b exp=1", bus_if.address_error); end
        fetch(16'd1, 13'h0002, 1'b1, 1'b0);
        total++; if (bus_if.address_error !== 1'b1) begin bad++; $display("FAIL aerr_sticky got=%b exp=1", bus_if.address_error); end
        fetch(16'h8000, EXP_ERR, 1'b1, 1'b0);
    endtask

    task automatic test_reset_mid_fetch();
        bus_if.instruction_bus_request = 1'b1;
        bus_if.instruction_bus_address = 16'd2;
        tick();
        bus_if.instruction_bus_request = 1'b0;
        tick();
        reset = 1'b1;
        #1;
        total++; if (bus_if.debug_state !== EXP_LOAD) begin bad++; $display("FAIL midrst_state got=%h exp=%h", bus_if.debug_state, EXP_LOAD); end
        total++; if (bus_if.instruction_bus_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid got=%b exp=0", bus_if.instruction_bus_valid); end
        total++; if (bus_if.instruction_bus_data !== 13'h0000) begin bad++; $display("FAIL midrst_data got=%h exp=0000", bus_if.instruction_bus_data); end
        total++; if (bus_if.address_error !== 1'b0) begin bad++; $display("FAIL midrst_aerr got=%b exp=0", bus_if.address_error); end
        expect_no_valid(2, "midrst_held");
        reset = 1'b0;
        expect_no_valid(8, "midrst_after");
        total++; if (bus_if.load_ready !== 1'b1) begin bad++; $display("FAIL midrst_load_ready got=%b exp=1", bus_if.load_ready); end
    endtask

    task automatic test_load_with_done();
        load_word(16'd5, 13'h0AAA, 1'b1);
        total++; if (bus_if.debug_state !== EXP_IDLE) begin bad++; $display("FAIL load_done_state got=%h exp=%h", bus_if.debug_state, EXP_IDLE); end
        fetch(16'd5, 13'h0AAA, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) fetch(16'(i), 13'(i + 1), 1'b0, 1'b0);
        tick();
    endtask

    task automatic test_halt();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        load_word(16'h0200, 13'h0777, 1'b0);
        total++; if (bus_if.address_error !== 1'b1) begin bad++; $display("FAIL load_aerr got=%b exp=1", bus_if.address_error); end
        pulse_done();
        fetch(16'd0, 13'h0001, 1'b1, 1'b0);
        bus_if.instruction_bus_request = 1'b1;
        bus_if.instruction_bus_address = 16'hFFFF;
        tick();
        bus_if.instruction_bus_request = 1'b0;
        total++; if (bus_if.halted !== 1'b1) begin bad++; $display("FAIL halted_set got=%b exp=1", bus_if.halted); end
        expect_no_valid(6, "halt_fetch");
        total++; if (bus_if.debug_state !== EXP_HALT) begin bad++; $display("FAIL halt_state got=%h exp=%h", bus_if.debug_state, EXP_HALT); end
        total++; if (bus_if.load_ready !== 1'b0) begin bad++; $display("FAIL halt_load_ready got=%b exp=0", bus_if.load_ready); end
        bus_if.instruction_bus_request = 1'b1;
        bus_if.instruction_bus_address = 16'd0;
        tick();
        bus_if.instruction_bus_request = 1'b0;
        expect_no_valid(8, "fetch_after_halt");
        total++; if (bus_if.halted !== 1'b1) begin bad++; $display("FAIL halted_sticky got=%b exp=1", bus_if.halted); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        idle_inputs();
        test_reset();
        test_load_and_fetch();
        test_back_to_back();
        test_wait_states();
        test_out_of_range();
        test_reset_mid_fetch();
        test_load_with_done();
        test_halt();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        bad++;
        $display("FAIL watchdog simulation did not complete");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ldst_instruction_memory.md
LDST_INSTRUCTION_MEMORY -- requirements
Module: ldst_instruction_memory

Interface
REQ-001 Parameter DEPTH_LOG2, default 8, number of word-address bits actually stored (2**DEPTH_LOG2 words of 13 bits).
REQ-002 Parameter WAIT_CYCLES, default 2, extra response latency in cycles, range 0..15, used only when LDST_IMEM_WAIT_EN is defined.
REQ-003 clock  input  1  rising-edge clock.
REQ-004 reset  input  1  reset, asynchronous, active-high.
REQ-005 load_valid  input  1  loader offers one program word.
REQ-006 load_address  input  16  word address of the offered word.
REQ-007 load_data  input  13  program word.
REQ-008 load_ready  output  1  word accepted this cycle when high together with load_valid.
REQ-009 load_done  input  1  single-cycle pulse that ends loading and enables fetch.
REQ-010 instruction_bus_request  input  1  sequencer fetch request.
REQ-011 instruction_bus_address  input  16  fetch word address.
REQ-012 instruction_bus_data  output  13  fetched instruction.
REQ-013 instruction_bus_valid  output  1  data valid, single-cycle pulse.
REQ-014 address_error  output  1  sticky flag: a fetch or load address was at or above 2**DEPTH_LOG2 (excluding 16'hFFFF).
REQ-015 halted  output  1  sticky flag: a fetch to 16'hFFFF was seen.

Function
REQ-016 The FSM SHALL have the states LOAD, IDLE, WAIT, RESPOND and HALT, and SHALL enter LOAD on reset.
REQ-017 In LOAD: load_ready=1; a load_valid word SHALL be written in the same cycle; requests SHALL be ignored; load_done SHALL move the FSM to IDLE next cycle.
REQ-018 If load_valid and load_done are high in the same cycle, the word SHALL be written and the FSM SHALL then go to IDLE.
REQ-019 A load address that is out of range SHALL NOT be written and SHALL set address_error.
REQ-020 In IDLE, a request SHALL latch the address; if the address is 16'hFFFF the FSM SHALL go to HALT, otherwise to RESPOND (or WAIT when wait states are enabled and WAIT_CYCLES>0).
REQ-021 RESPOND SHALL drive instruction_bus_valid=1 for exactly one cycle with the registered word, then go to IDLE; base latency is request edge to valid = 2 cycles.
REQ-022 An out-of-range fetch SHALL return 13'h1FFF with valid and SHALL set address_error.
REQ-023 Requests arriving in WAIT or RESPOND SHALL be ignored; the sequencer SHALL hold off until valid.
REQ-024 HALT SHALL be terminal until reset: halted=1, valid=0, load_ready=0, requests ignored.
REQ-025 instruction_bus_data SHALL hold its last value when valid=0.
REQ-026 load_ready SHALL be 0 in every state except LOAD.

Reset
REQ-027 Reset SHALL asynchronously force: state=LOAD, instruction_bus_data=13'h0000, instruction_bus_valid=0, load_ready=1 after release, address_error=0, halted=0, and wait counter=0.
REQ-028 Memory contents SHALL NOT be cleared by reset.
REQ-029 Reset asserted mid-fetch SHALL drop the pending response, and no valid SHALL follow.

Configuration
REQ-030 With LDST_IMEM_WAIT_EN defined, a 4-bit counter in WAIT SHALL delay RESPOND by WAIT_CYCLES cycles, so latency = 2+WAIT_CYCLES.
REQ-031 Without LDST_IMEM_WAIT_EN, the WAIT state and the counter SHALL be absent, and latency SHALL be fixed at 2.

Structure
REQ-032 Package ldst_imem_pkg SHALL hold the state enum, HALT_ADDRESS=16'hFFFF, ERROR_WORD=13'h1FFF and the data width of 13.
REQ-033 The storage array SHALL be the sub-module ldst_imem_array: 1 write port and 1 registered read port, with no reset.

Verification
REQ-034 Load the words at 0..3 (13'h0001, 0002, 0003, 0004), pulse load_done, then fetch address 2 -> valid 2 cycles later with data 13'h0003.
REQ-035 Fetch 16'h0100 with DEPTH_LOG2=8 -> data 13'h1FFF with valid, address_error=1, and the flag stays high on a later legal fetch.
REQ-036 Fetch 16'hFFFF -> halted=1 next cycle and no valid; a following fetch of address 0 produces no valid.
REQ-037 With LDST_IMEM_WAIT_EN and WAIT_CYCLES=3, fetch address 1 -> valid exactly 5 cycles after the request edge with data 13'h0002.
REQ-038 Assert reset during WAIT/RESPOND -> no valid, state LOAD, and the memory still returns the loaded words after a new load_done.
REQ-039 Assert load_valid and load_done together at address 5 (13'h0AAA) -> the word is written and a fetch of address 5 returns 13'h0AAA.
